vga_sync_gen: RTL

VGA raster timing generator for the 640x480@60 Hz display path. It runs on the 100 MHz system clock and advances one pixel position per cycle in which the 25 MHz pixel strobe from the clock-divider stage is high. It produces horizontal/vertical sync, the active-video flag, raster coordinates and a frame-start pulse. Its outputs feed the pixel-fetch and colour-output stages.

---
 rtl/vga_sync_gen_if.sv | 33 +++
 rtl/vga_sync_gen.sv | 133 +++++++++++++
 2 files changed

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle between the sync generator and the pixel-fetch / colour stages.
// The master side owns the raster outputs; the slave side supplies the pixel strobe.
interface vga_sync_gen_if #(
    parameter int CW = 10
);
    logic          pix_en;
    logic          hsync;
    logic          vsync;
    logic          video_on;
    logic [CW-1:0] h_count;
    logic [CW-1:0] v_count;
    logic          frame_start;

    modport master (
        input  pix_en,
        output hsync,
        output vsync,
        output video_on,
        output h_count,
        output v_count,
        output frame_start
    );

    modport slave (
        output pix_en,
        input  hsync,
        input  vsync,
        input  video_on,
        input  h_count,
        input  v_count,
        input  frame_start
    );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: counters, horizontal/vertical phase FSMs and registered
// sync / active-video / frame-start outputs, advancing one position per pixel strobe.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    vga_sync_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST       = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_FP_START   = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_START = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_BP_START   = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_LAST       = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_FP_START   = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SYNC_START = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_BP_START   = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);

    typedef enum logic [1:0] {
        PH_ACTIVE = 2'd0,
        PH_FP     = 2'd1,
        PH_SYNC   = 2'd2,
        PH_BP     = 2'd3
    } phase_t;

    // Phase is always re-derived from the count it describes, so the FSM and counter cannot drift apart.
    function automatic phase_t phase_of(input logic [CW-1:0] cnt,
                                        input logic [CW-1:0] fp_start,
                                        input logic [CW-1:0] sync_start,
                                        input logic [CW-1:0] bp_start);
        phase_t ph;
        if (cnt < fp_start) begin
            ph = PH_ACTIVE;
        end else if (cnt < sync_start) begin
            ph = PH_FP;
        end else if (cnt < bp_start) begin
            ph = PH_SYNC;
        end else begin
            ph = PH_BP;
        end
        return ph;
    endfunction

    logic [CW-1:0] h_cnt_r;
    logic [CW-1:0] v_cnt_r;
    phase_t        h_phase_r;
    phase_t        v_phase_r;
    logic          hsync_r;
    logic          vsync_r;
    logic          video_on_r;
    logic          frame_start_r;

    logic [CW-1:0] h_nxt_s;
    logic [CW-1:0] v_nxt_s;
    phase_t        h_phase_nxt_s;
    phase_t        v_phase_nxt_s;
    logic          line_wrap_s;

    // Next raster position and phases for the current pixel strobe.
    always_comb begin
        h_nxt_s       = h_cnt_r;
        v_nxt_s       = v_cnt_r;
        h_phase_nxt_s = h_phase_r;
        v_phase_nxt_s = v_phase_r;
        line_wrap_s   = (h_cnt_r == H_LAST);
        if (vga.pix_en) begin
            if (line_wrap_s) begin
                h_nxt_s = CNT_ZERO;
                if (v_cnt_r == V_LAST) begin
                    v_nxt_s = CNT_ZERO;
                end else begin
                    v_nxt_s = v_cnt_r + CNT_ONE;
                end
                v_phase_nxt_s = phase_of(v_nxt_s, V_FP_START, V_SYNC_START, V_BP_START);
            end else begin
                h_nxt_s = h_cnt_r + CNT_ONE;
                v_nxt_s = v_cnt_r;
            end
            h_phase_nxt_s = phase_of(h_nxt_s, H_FP_START, H_SYNC_START, H_BP_START);
        end else begin
            h_nxt_s = h_cnt_r;
            v_nxt_s = v_cnt_r;
        end
    end

    // Raster state and registered outputs; everything moves together on a pixel strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_r       <= H_LAST;
            v_cnt_r       <= V_LAST;
            h_phase_r     <= PH_BP;
            v_phase_r     <= PH_BP;
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            video_on_r    <= 1'b0;
            frame_start_r <= 1'b0;
        end else if (vga.pix_en) begin
            h_cnt_r       <= h_nxt_s;
            v_cnt_r       <= v_nxt_s;
            h_phase_r     <= h_phase_nxt_s;
            v_phase_r     <= v_phase_nxt_s;
            hsync_r       <= (h_phase_nxt_s == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            vsync_r       <= (v_phase_nxt_s == PH_SYNC) ? SYNC_POL : ~SYNC_POL;
            video_on_r    <= (h_phase_nxt_s == PH_ACTIVE) && (v_phase_nxt_s == PH_ACTIVE);
            frame_start_r <= (h_nxt_s == CNT_ZERO) && (v_nxt_s == CNT_ZERO);
        end else begin
            frame_start_r <= 1'b0;
        end
    end

    assign vga.h_count     = h_cnt_r;
    assign vga.v_count     = v_cnt_r;
    assign vga.hsync       = hsync_r;
    assign vga.vsync       = vsync_r;
    assign vga.video_on    = video_on_r;
    assign vga.frame_start = frame_start_r;

endmodule
